// File: rtl/trapezoid_pkg.sv
// Shared types for the trapezoid command driver.
// Descriptor layout matches the host bus packing: x0/y0 occupy the top byte,
// so element [k] of each packed array is vertex Pk.
package trapezoid_pkg;

    localparam int unsigned TRAP_VERTS = 4;
    localparam int unsigned COORD_W    = 8;

    typedef struct packed {
        logic [0:TRAP_VERTS-1][COORD_W-1:0] x;
        logic [0:TRAP_VERTS-1][COORD_W-1:0] y;
    } trap_desc_t;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SEND,
        WAIT_HI,
        WAIT_LO
    } tx_state_t;

endpackage

// File: rtl/trapezoid_tx_fifo.sv
// Descriptor FIFO with show-ahead read data and an occupancy count.
// Ports: clk/reset (async, active-high), push/wdata, pop/rdata, count, full, empty.
// Pushes while full and pops while empty are ignored.
module trapezoid_tx_fifo
    import trapezoid_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  trap_desc_t               wdata,
    input  logic                     pop,
    output trap_desc_t               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    trap_desc_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^n.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/trapezoid_tx.sv
// Command-side driver for the trapezoid renderer: queues host descriptors and
// launches them one at a time as a four-beat nt/xi/yi burst, then tracks busy.
// Ports: clk, reset (async, active-high); host side in_valid/in_ready/in_x/in_y;
// renderer side busy/nt/xi/yi; status done, err, pending.
// Optional watchdog on the busy handshake: define TRAP_TX_TIMEOUT_EN.
module trapezoid_tx
    import trapezoid_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TO_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic        busy,
    output logic        nt,
    output logic [7:0]  xi,
    output logic [7:0]  yi,
    output logic        done,
    output logic        err,
    output logic [2:0]  pending
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned BW = $clog2(TRAP_VERTS);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TO_CYCLES < 1) begin : g_bad_param
        $error("trapezoid_tx: DEPTH must be a power of two >= 2 and TO_CYCLES >= 1");
    end

    trap_desc_t    in_desc, fifo_head;
    logic          push, pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   count_w;

    tx_state_t     state_q, state_d;
    trap_desc_t    desc_q, desc_d;
    logic [BW-1:0] beat_q, beat_d, beat_nxt;
    logic          nt_q, nt_d;
    logic [7:0]    xi_q, xi_d, yi_q, yi_d;
    logic          done_q, done_d;

`ifdef TRAP_TX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TO_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          err_q, err_d;
`endif

    assign in_desc.x = in_x;
    assign in_desc.y = in_y;
    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;

    trapezoid_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (in_desc),
        .pop   (pop),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Occupancy reported on a 3-bit port, saturating for deep FIFOs.
    assign count_w = 32'(fifo_count);
    assign pending = (count_w > 32'd7) ? 3'd7 : 3'(count_w);

    assign beat_nxt = beat_q + BW'(1);

    // Launch sequencer; nt/xi/yi are produced one cycle ahead so they line up
    // with the state that owns them.
    always_comb begin
        state_d = state_q;
        desc_d  = desc_q;
        beat_d  = beat_q;
        nt_d    = 1'b0;
        xi_d    = xi_q;
        yi_d    = yi_q;
        done_d  = 1'b0;
        pop     = 1'b0;
`ifdef TRAP_TX_TIMEOUT_EN
        to_cnt_d = '0;
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !busy) begin
                    pop     = 1'b1;
                    desc_d  = fifo_head;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!busy) begin
                    state_d = SEND;
                    beat_d  = '0;
                    nt_d    = 1'b1;
                    xi_d    = desc_q.x[0];
                    yi_d    = desc_q.y[0];
                end
            end
            SEND: begin
                if (beat_q == BW'(TRAP_VERTS - 1)) begin
                    state_d = WAIT_HI;
                end else begin
                    beat_d = beat_nxt;
                    xi_d   = desc_q.x[beat_nxt];
                    yi_d   = desc_q.y[beat_nxt];
                end
            end
            WAIT_HI: begin
                if (busy) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!busy) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef TRAP_TX_TIMEOUT_EN
        // Counter restarts on every state change; expiry abandons the trapezoid.
        if ((state_q == WAIT_HI || state_q == WAIT_LO) && state_d == state_q) begin
            if (to_cnt_q == TW'(TO_CYCLES - 1)) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            desc_q  <= '0;
            beat_q  <= '0;
            nt_q    <= 1'b0;
            xi_q    <= '0;
            yi_q    <= '0;
            done_q  <= 1'b0;
`ifdef TRAP_TX_TIMEOUT_EN
            to_cnt_q <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            beat_q  <= beat_d;
            nt_q    <= nt_d;
            xi_q    <= xi_d;
            yi_q    <= yi_d;
            done_q  <= done_d;
`ifdef TRAP_TX_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign nt   = nt_q;
    assign xi   = xi_q;
    assign yi   = yi_q;
    assign done = done_q;
`ifdef TRAP_TX_TIMEOUT_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_trapezoid_tx.sv
// Directed bench for trapezoid_tx: launch timing, burst order, queueing,
// simultaneous push/pop, reset mid-burst and the busy watchdog.
module tb_trapezoid_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        busy;
    logic        nt;
    logic [7:0]  xi;
    logic [7:0]  yi;
    logic        done;
    logic        err;
    logic [2:0]  pending;

    int n_total = 0;
    int n_pass  = 0;

    trapezoid_tx #(.DEPTH(4), .TO_CYCLES(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .busy     (busy),
        .nt       (nt),
        .xi       (xi),
        .yi       (yi),
        .done     (done),
        .err      (err),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk_x(input int i);
        return {8'(10 + i), 8'(20 + i), 8'(5 + i), 8'(25 + i)};
    endfunction

    function automatic logic [31:0] mk_y(input int i);
        return {8'(3 + i), 8'(3 + i), 8'(9 + i), 8'(9 + i)};
    endfunction

    // Waits (bounded) for nt, checks the four beats, plays a short busy pulse
    // and checks done; returns in the done cycle.
    task automatic run_one(input string tag, input logic [31:0] ex, input logic [31:0] ey,
                           input int exp_lat);
        int n;
        logic saw_done;
        logic [16:0] e;
        n = 0;
        while (nt !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            e = {(k == 0) ? 1'b1 : 1'b0, ex[31 - 8*k -: 8], ey[31 - 8*k -: 8]};
            chk($sformatf("%s beat%0d", tag, k), 32'({nt, xi, yi}), 32'(e));
        end
        busy = 1'b1;
        saw_done = 1'b0;
        repeat (5) begin
            tick();
            saw_done |= done;
        end
        chk({tag, " no early done"}, 32'(saw_done), 32'd0);
        busy = 1'b0;
        tick();
        chk({tag, " done"}, 32'(done), 32'd1);
    endtask

    initial begin
        logic flag;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        busy     = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst outs", 32'({nt, xi, yi, done, err}), 32'd0);
        chk("rst pending", 32'(pending), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        tick();

        // Single trapezoid: push in cycle t
        in_valid = 1'b1;
        in_x = 32'h0A14_0519;
        in_y = 32'h0303_0909;
        tick();                                         // t+1
        in_valid = 1'b0;
        chk("single t1 pending", 32'(pending), 32'd1);
        chk("single t1 nt", 32'(nt), 32'd0);
        tick();                                         // t+2
        chk("single t2 nt", 32'(nt), 32'd0);
        chk("single t2 pending", 32'(pending), 32'd0);
        tick();                                         // t+3
        chk("single beat0", 32'({nt, xi, yi}), 32'({1'b1, 8'd10, 8'd3}));
        tick();
        chk("single beat1", 32'({nt, xi, yi}), 32'({1'b0, 8'd20, 8'd3}));
        tick();
        chk("single beat2", 32'({nt, xi, yi}), 32'({1'b0, 8'd5, 8'd9}));
        tick();
        chk("single beat3", 32'({nt, xi, yi}), 32'({1'b0, 8'd25, 8'd9}));
        busy = 1'b1;
        flag = 1'b0;
        repeat (50) begin
            tick();
            flag |= done | nt;
        end
        chk("single quiet while busy", 32'(flag), 32'd0);
        busy = 1'b0;
        tick();
        chk("single done", 32'(done), 32'd1);
        tick();
        chk("single done pulse", 32'(done), 32'd0);
        chk("single hold", 32'({nt, xi, yi}), 32'({1'b0, 8'd25, 8'd9}));

        // Queue fill with busy held high
        busy = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill in_ready%0d", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
            in_valid = 1'b1;
            in_x = mk_x(i);
            in_y = mk_y(i);
            tick();
            flag |= nt;
        end
        in_valid = 1'b0;
        chk("fill pending", 32'(pending), 32'd4);
        chk("fill in_ready", 32'(in_ready), 32'd0);
        chk("fill no nt", 32'(flag), 32'd0);

        // Back-to-back drain, order preserved, done->nt spacing 2
        busy = 1'b0;
        for (int i = 0; i < 4; i++) run_one($sformatf("b2b%0d", i), mk_x(i), mk_y(i), 2);
        chk("b2b empty", 32'(pending), 32'd0);

        // Push coinciding with the IDLE->ARM pop
        busy = 1'b1;
        for (int i = 4; i < 6; i++) begin
            in_valid = 1'b1;
            in_x = mk_x(i);
            in_y = mk_y(i);
            tick();
        end
        chk("pp before", 32'(pending), 32'd2);
        busy = 1'b0;
        in_x = mk_x(6);
        in_y = mk_y(6);
        tick();
        in_valid = 1'b0;
        chk("pp after", 32'(pending), 32'd2);
        run_one("pp0", mk_x(4), mk_y(4), 1);
        run_one("pp1", mk_x(5), mk_y(5), 2);
        run_one("pp2", mk_x(6), mk_y(6), 2);

        // Reset during beat 2, with another descriptor queued
        in_valid = 1'b1;
        in_x = 32'h0102_0304;
        in_y = 32'h0101_0707;
        tick();                                         // t+1
        in_x = mk_x(9);
        in_y = mk_y(9);
        tick();                                         // t+2
        in_valid = 1'b0;
        tick();                                         // t+3
        chk("rst-send beat0", 32'({nt, xi, yi}), 32'({1'b1, 8'd1, 8'd1}));
        tick();
        tick();                                         // beat 2
        chk("rst-send beat2", 32'({nt, xi, yi}), 32'({1'b0, 8'd3, 8'd7}));
        chk("rst-send pending", 32'(pending), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst-send outs", 32'({nt, xi, yi}), 32'd0);
        chk("rst-send cleared", 32'(pending), 32'd0);
        tick();
        reset = 1'b0;
        flag = 1'b0;
        repeat (10) begin
            tick();
            flag |= done | nt;
        end
        chk("rst-send quiet", 32'(flag), 32'd0);
        chk("rst-send in_ready", 32'(in_ready), 32'd1);

        // Busy never rises after the burst
        in_valid = 1'b1;
        in_x = mk_x(7);
        in_y = mk_y(7);
        tick();                                         // t+1
        in_x = mk_x(8);
        in_y = mk_y(8);
        tick();                                         // t+2
        in_valid = 1'b0;
        tick();                                         // t+3
        chk("wd beat0", 32'({nt, xi}), 32'({1'b1, 8'd17}));
        repeat (4) tick();                              // t+7, WAIT_HI entry
        chk("wd pending", 32'(pending), 32'd1);
`ifdef TRAP_TX_TIMEOUT_EN
        flag = 1'b0;
        repeat (63) begin
            tick();
            flag |= err | done | nt;
        end
        chk("wd quiet", 32'(flag), 32'd0);
        tick();                                         // t+71
        chk("wd err", 32'({err, done}), 32'({1'b1, 1'b0}));
        tick();                                         // t+72
        chk("wd err pulse", 32'(err), 32'd0);
        chk("wd popped", 32'(pending), 32'd0);
        tick();                                         // t+73
        chk("wd next launch", 32'({nt, xi, yi}), 32'({1'b1, 8'd18, 8'd11}));
`else
        flag = 1'b0;
        repeat (80) begin
            tick();
            flag |= err | done | nt;
        end
        chk("nowd waits", 32'(flag), 32'd0);
        chk("nowd pending", 32'(pending), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
